// File: rtl/cpu_ex.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and EX/MEM pipeline registers.
// Optional multi-cycle shift-add multiplier (func 0x10) enabled by defining CPU_EX_MUL_EN.
module cpu_ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_rfa,
  input  logic [31:0] id_rfb,
  input  logic [31:0] id_se,
  input  logic [4:0]  id_shamt,
  input  logic [5:0]  id_func,
  input  logic [5:0]  id_alucontrol,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rf_waddr,
  input  logic        id_rfw,
  input  logic        id_drw,
  input  logic        id_rfbse,
  input  logic        id_j,
  input  logic        id_b,
  input  logic        id_jjr,
  input  logic [1:0]  id_wbsource,
  input  logic [25:0] id_jaddr,
  input  logic [31:0] id_pc,
  input  logic        mem_rfw,
  input  logic [4:0]  mem_rf_waddr,
  input  logic [31:0] mem_alu_r,
  input  logic        wb_rfw,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [31:0] wb_rf_wdata,
  output logic [31:0] p_alu_r,
  output logic [31:0] p_rfb,
  output logic [31:0] p_link,
  output logic [4:0]  p_rf_waddr,
  output logic        p_rfw,
  output logic        p_drw,
  output logic [1:0]  p_wbsource,
  output logic        c_br_taken,
  output logic [31:0] c_br_target,
  output logic        c_stall
);

  logic [31:0] fwd_a, fwd_b, alu_b, alu_r, ex_result;

  // Memory stage is younger than writeback, so it wins; register 0 is hardwired zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fwd_a = id_rfa;
    fwd_b = id_rfb;
    if (mem_rfw && (mem_rf_waddr != 5'd0) && (mem_rf_waddr == id_rs))
      fwd_a = mem_alu_r;
    else if (wb_rfw && (wb_rf_waddr != 5'd0) && (wb_rf_waddr == id_rs))
      fwd_a = wb_rf_wdata;
    if (mem_rfw && (mem_rf_waddr != 5'd0) && (mem_rf_waddr == id_rt))
      fwd_b = mem_alu_r;
    else if (wb_rfw && (wb_rf_waddr != 5'd0) && (wb_rf_waddr == id_rt))
      fwd_b = wb_rf_wdata;
  end

  assign alu_b = id_rfbse ? id_se : fwd_b;

  always_comb begin
    alu_r = 32'd0;
    if (id_alucontrol == 6'h00) begin
      case (id_func)
        6'h20, 6'h21: alu_r = fwd_a + alu_b;
        6'h22, 6'h23: alu_r = fwd_a - alu_b;
        6'h24:        alu_r = fwd_a & alu_b;
        6'h25:        alu_r = fwd_a | alu_b;
        6'h27:        alu_r = ~(fwd_a | alu_b);
        6'h2a:        alu_r = {31'd0, $signed(fwd_a) < $signed(alu_b)};
        6'h2b:        alu_r = {31'd0, fwd_a < alu_b};
        6'h00:        alu_r = alu_b << id_shamt;
        6'h02:        alu_r = alu_b >> id_shamt;
        default:      alu_r = 32'd0;
      endcase
    end else begin
      case (id_alucontrol)
        6'h08, 6'h09: alu_r = fwd_a + alu_b;
        6'h0a:        alu_r = {31'd0, $signed(fwd_a) < $signed(alu_b)};
        6'h0b:        alu_r = {31'd0, fwd_a < alu_b};
        6'h0c:        alu_r = fwd_a & alu_b;
        6'h0d:        alu_r = fwd_a | alu_b;
        6'h0f:        alu_r = {alu_b[15:0], 16'h0000};
        6'h23, 6'h2b: alu_r = fwd_a + alu_b;
        default:      alu_r = 32'd0;
      endcase
    end
  end

  always_comb begin
    c_br_taken  = 1'b0;
    c_br_target = id_pc + 32'd4 + (id_se << 2);
    if (id_j)
      c_br_target = id_jjr ? fwd_a : {id_pc[31:28], id_jaddr, 2'b00};
    if (!c_stall) begin
      if (id_j)
        c_br_taken = 1'b1;
      else if (id_b && (id_alucontrol == 6'h04) && (fwd_a == fwd_b))
        c_br_taken = 1'b1;
      else if (id_b && (id_alucontrol == 6'h05) && (fwd_a != fwd_b))
        c_br_taken = 1'b1;
    end
  end

`ifdef CPU_EX_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  mul_state_t  state, state_nx;
  logic [4:0]  count;
  logic [31:0] mcand, mplier, prod;
  logic        is_mul;

  assign is_mul = (id_alucontrol == 6'h00) && (id_func == 6'h10);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state  <= S_IDLE;
      count  <= 5'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      prod   <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (is_mul) begin
          count  <= 5'd0;
          mcand  <= fwd_a;
          mplier <= alu_b;
          prod   <= 32'd0;
        end
        S_BUSY: begin
          count  <= count + 5'd1;
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        default: ;
      endcase
    end
  end

  // One stall cycle in IDLE plus 32 in BUSY; DONE releases the stall and retires the product.
  always_comb begin
    state_nx = state;
    c_stall  = 1'b0;
    case (state)
      S_IDLE: if (is_mul) begin
        state_nx = S_BUSY;
        c_stall  = 1'b1;
      end
      S_BUSY: begin
        c_stall = 1'b1;
        if (count == 5'd31) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign ex_result = (state == S_DONE) ? prod : alu_r;
`else
  assign c_stall   = 1'b0;
  assign ex_result = alu_r;
`endif

  // A stall loads a bubble so nothing downstream writes state.
  always_ff @(posedge clk) begin
    if (rst || c_stall) begin
      p_alu_r    <= 32'd0;
      p_rfb      <= 32'd0;
      p_link     <= 32'd0;
      p_rf_waddr <= 5'd0;
      p_rfw      <= 1'b0;
      p_drw      <= 1'b0;
      p_wbsource <= 2'd0;
    end else begin
      p_alu_r    <= ex_result;
      p_rfb      <= fwd_b;
      p_link     <= id_pc + 32'd8;
      p_rf_waddr <= id_rf_waddr;
      p_rfw      <= id_rfw;
      p_drw      <= id_drw;
      p_wbsource <= id_wbsource;
    end
  end

endmodule

// File: doc/cpu_ex.md
CPU_EX -- requirements
Module: cpu_ex

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 id_rfa, id_rfb  input  32 each  register operands from decode.
REQ-004 id_se  input  32  extended immediate.
REQ-005 id_shamt  input  5  shift amount.
REQ-006 id_func  input  6  R-type function.
REQ-007 id_alucontrol  input  6  opcode.
REQ-008 id_rs, id_rt, id_rf_waddr  input  5 each  source and destination register numbers.
REQ-009 id_rfw, id_drw, id_rfbse, id_j, id_b, id_jjr  input  1 each  decode control flags.
REQ-010 id_wbsource  input  2  writeback select.
REQ-011 id_jaddr  input  26  jump field.
REQ-012 id_pc  input  32  instruction PC.
REQ-013 mem_rfw, mem_rf_waddr, mem_alu_r  input  1/5/32  memory-stage forward source.
REQ-014 wb_rfw, wb_rf_waddr, wb_rf_wdata  input  1/5/32  writeback forward source.
REQ-015 p_alu_r, p_rfb, p_link  output  32 each  registered ALU result, store data, PC+8.
REQ-016 p_rf_waddr, p_rfw, p_drw, p_wbsource  output  5/1/1/2  registered controls to memory stage.
REQ-017 c_br_taken, c_br_target  output  1/32  combinational redirect to fetch.
REQ-018 c_stall  output  1  combinational; fetch/decode hold while high.

Function
REQ-019 Operand forwarding SHALL prefer mem (mem_rfw, waddr==rs/rt, waddr!=0) over wb, else id_rfa/id_rfb; register 0 never forwarded.
REQ-020 Operand B SHALL be id_se when id_rfbse=1, else forwarded rfb.
REQ-021 Opcode 0x00 ops by func: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2a slt signed, 0x2b sltu, 0x00 sll by shamt, 0x02 srl by shamt; 32-bit wrap, no overflow trap.
REQ-022 I-type: 0x08/0x09 add, 0x0a slti, 0x0b sltiu, 0x0c andi, 0x0d ori, 0x0f lui ({imm[15:0],16'h0}), 0x23/0x2b address add; other codes yield 0.
REQ-023 c_br_taken SHALL be 1 when id_j, or id_b with 0x04 and A==B or 0x05 and A!=B.
REQ-024 c_br_target: branch id_pc+4+(id_se<<2); jump/jal {id_pc[31:28],id_jaddr,2'b00}; id_jjr=1 with id_j -> forwarded A.
REQ-025 Pipeline registers SHALL capture all p_* every cycle when c_stall=0, one-cycle latency; p_rfb is forwarded rfb; p_link=id_pc+8.
REQ-026 While c_stall=1, outputs SHALL be a bubble: p_rfw=0, p_drw=0, others 0; c_br_taken=0.

Reset
REQ-027 rst SHALL clear all p_* to 0, multiplier FSM to IDLE, counter to 0, c_stall=0 next cycle.
REQ-028 rst mid-multiply SHALL abort; no product ever written.

Configuration
REQ-029 With CPU_EX_MUL_EN defined, func 0x10 (opcode 0x00) SHALL be an unsigned shift-add multiply, low 32 bits.
REQ-030 Multiplier FSM: IDLE (mul seen -> BUSY, count=0), BUSY (32 cycles, count 0..31, -> DONE at 31), DONE (product captured into p_alu_r with controls, -> IDLE).
REQ-031 c_stall SHALL be high in IDLE-with-mul and all BUSY cycles (33 cycles), low in DONE; decode inputs held stable throughout.
REQ-032 Without CPU_EX_MUL_EN, func 0x10 yields 0, c_stall tied 0, no FSM logic.

Verification
REQ-033 add r3: A=5,B=7 func 0x20 -> p_alu_r=12 next edge, p_rfw=1, p_rf_waddr=3.
REQ-034 mem_rfw=1 waddr=4 alu_r=0xAA and wb waddr=4 data=0xBB, rs=4 -> A=0xAA; rs=0 -> A=id_rfa.
REQ-035 beq pc=0x100 se=3 A==B -> c_br_taken=1, target 0x110; bne same operands -> taken=0.
REQ-036 slt A=0xFFFFFFFF B=1 -> 1; sltu same -> 0; lui imm 0x1234 -> 0x12340000.
REQ-037 CPU_EX_MUL_EN: 0x10000*0x10001 -> stall 33 cycles, p_rfw=0 then, product 0x00010000; rst at cycle 10 -> stall low, p_* 0.
